dl_pipe_reg: RTL
================

# dl_pipe_reg

Parametrised, elastic pipeline register chain: WIDTH-bit data through DEPTH register stages. Each stage has a valid/ready handshake, so downstream backpressure stalls the chain without losing or duplicating data. It replaces bare D flip-flops wherever a datapath needs retiming and flow control, for example between fetch/decode/execute boundaries in the core.

## Interface
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 1, number of register stages (0 = combinational pass-through)
- RESET_VAL, '0, data value loaded into every stage on reset

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous pipeline clear (present only with DL_PIPE_REG_FLUSH_EN)
- in_valid  input  1  upstream has data
- in_ready  output  1  chain accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  data from the last stage

## Operation
- The design uses one clock, clk. Reset rst is asynchronous and active-high.
- Each stage k (0 = input side, DEPTH-1 = output side) holds v[k] and d[k].
- Stage ready: r[k] = !v[k] || r[k+1], with r[DEPTH] = out_ready. in_ready = r[0].
- A transfer occurs at a port when valid && ready are both high at the rising edge.
- Stage k loads on the edge when r[k] is high:
  - v[k] <= v[k-1] (with v[-1] = in_valid)
  - d[k] <= d[k-1] (with d[-1] = in_data)
  - d[k] is written only when the incoming valid is 1. Bubbles do not toggle data.
- out_valid = v[DEPTH-1]. out_data = d[DEPTH-1].
- Stall: if out_ready=0 and every stage is valid, then in_ready=0 and all stages hold their contents.
- Bubble collapsing: an empty stage accepts new data even when downstream is stalled, so bubbles are squeezed out.
- DEPTH=0: in_ready=out_ready, out_valid=in_valid, out_data=in_data. No registers.
- Ordering: data leaves in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all v[k]=0, all d[k]=RESET_VAL
  - out_valid=0, out_data=RESET_VAL
  - in_ready=1 whenever DEPTH≥1
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, provided there are no stalls. It is presented in the cycle following edge N+DEPTH-1.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_ready through the DEPTH-stage ready chain. No other comb path runs from input to output when DEPTH≥1.
- Simultaneous push and pop on a full chain: allowed. All stages shift and occupancy stays DEPTH.
- Reset asserted mid-transfer: all in-flight beats are discarded. After rst deasserts, the first edge can accept new data.
- Upstream protocol: the source must hold in_valid/in_data stable until accepted. The block does not check this.

## Configuration
- DL_PIPE_REG_FLUSH_EN defined:
  - The flush port exists.
  - While flush=1: in_ready=0 and out_valid=0 in the same cycle, so no transfers occur.
  - The next edge clears all v[k]. d[k] is left unchanged.
  - flush has priority over any load.
- Not defined: there is no flush port, and the logic behaves as if flush=0.

## Structure
- Shared package dl_pkg holds:
  - DL_PIPE_W_DEFAULT (32)
  - typedef dl_pipe_beat_t, a struct {valid, data} used by stage instances
- Sub-module dl_pipe_stage implements one valid/ready stage with WIDTH and RESET_VAL parameters.
- dl_pipe_reg generate-instantiates DEPTH copies of dl_pipe_stage and chains the ready signals. The DEPTH=0 branch is pure wiring.
- Include guard style matches the existing design_lib files.

## Test plan
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, assert rst asynchronously between edges -> out_valid=0 and out_data=8'hA5 immediately, in_ready=1.
- Streaming: DEPTH=3, out_ready=1, push 0x01..0x0A on consecutive cycles -> 0x01 is presented after edge 3, and 10 beats come out in order on consecutive cycles.
- Backpressure: DEPTH=3, out_ready=0, push 0x11, 0x22, 0x33, 0x44 -> in_ready falls after three accepts and 0x44 is held. Raise out_ready -> output is 0x11, 0x22, 0x33, 0x44 with no loss.
- Bubble collapse: DEPTH=4, push 0x5 then idle 2 cycles then push 0x6, with out_ready=0 -> both beats are held in stages 3 and 2, and in_ready stays 1.
- Full push/pop: DEPTH=2, chain full, in_valid=1 and out_ready=1 for 5 cycles -> one beat out per cycle, occupancy stays 2, order preserved.
- Flush (macro on): DEPTH=3 with 3 valid beats, pulse flush one cycle with in_valid=1 -> out_valid=0 and in_ready=0 that cycle, chain is empty afterwards, and the input beat is not accepted.

Source files
------------

// File: rtl/dl_pkg.sv
// Shared types and defaults for the design_lib pipeline register blocks.
`ifndef DL_PKG_SV
`define DL_PKG_SV

package dl_pkg;

    // Default datapath width for pipeline register instances.
    localparam int DL_PIPE_W_DEFAULT = 32;

    // One beat held by a pipeline stage: a valid flag plus its payload.
    // Blocks built at a different width declare a struct with this same
    // {valid, data} layout at their own width and hand it to the stages.
    typedef struct packed {
        logic                         valid;
        logic [DL_PIPE_W_DEFAULT-1:0] data;
    } dl_pipe_beat_t;

endpackage

`endif // DL_PKG_SV

// File: rtl/dl_pipe_stage.sv
// One elastic valid/ready register stage. An empty stage always accepts,
// which lets bubbles collapse while the output is stalled. flush clears the
// valid flag on the next edge and wins over any load.
`ifndef DL_PIPE_STAGE_SV
`define DL_PIPE_STAGE_SV

module dl_pipe_stage
    import dl_pkg::*;
#(
    parameter int               WIDTH     = DL_PIPE_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter type              beat_t    = dl_pipe_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  beat_t in_beat,
    output logic  in_ready,
    output beat_t out_beat,
    input  logic  out_ready
);

    beat_t q;

    // Ready when empty, or when the held beat leaves this same edge.
    assign in_ready = !q.valid || out_ready;
    assign out_beat = q;

    // Stage register: reset, flush, or load from the upstream stage.
    // NOTE: state updates use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking would shift a beat through the
    // whole chain in a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.valid <= 1'b0;
            // NOTE: the payload is reset too, so out_data shows RESET_VAL
            // rather than X until the first beat arrives.
            q.data  <= RESET_VAL;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (in_ready) begin
            q.valid <= in_beat.valid;
            // Bubbles move the valid flag only; the payload keeps its value.
            if (in_beat.valid) begin
                q.data <= in_beat.data;
            end
        end
    end

endmodule

`endif // DL_PIPE_STAGE_SV

// File: rtl/dl_pipe_reg.sv
// Elastic pipeline register chain: WIDTH-bit data through DEPTH valid/ready
// stages. DEPTH=0 is a pure wire. Build option: DL_PIPE_REG_FLUSH_EN adds a
// synchronous flush port that clears every stage's valid flag.
`ifndef DL_PIPE_REG_SV
`define DL_PIPE_REG_SV

module dl_pipe_reg
    import dl_pkg::*;
#(
    parameter int               WIDTH     = DL_PIPE_W_DEFAULT,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DL_PIPE_REG_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Same {valid, data} layout as dl_pipe_beat_t, at this instance's width.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic flush_i;

`ifdef DL_PIPE_REG_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    if (DEPTH == 0) begin : g_wire
        // No storage: handshake and data pass straight through.
        assign in_ready  = out_ready && !flush_i;
        assign out_valid = in_valid && !flush_i;
        assign out_data  = in_data;
    end else begin : g_chain
        // beat[k] feeds stage k; ready[k] is stage k's ready back upstream.
        beat_t beat  [DEPTH+1];
        logic  ready [DEPTH+1];

        assign beat[0].valid = in_valid;
        assign beat[0].data  = in_data;
        assign ready[DEPTH]  = out_ready;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            dl_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL),
                .beat_t    (beat_t)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush_i),
                .in_beat   (beat[k]),
                .in_ready  (ready[k]),
                .out_beat  (beat[k+1]),
                .out_ready (ready[k+1])
            );
        end

        // Flush masks both ports for the cycle so no transfer can happen.
        assign in_ready  = ready[0] && !flush_i;
        assign out_valid = beat[DEPTH].valid && !flush_i;
        assign out_data  = beat[DEPTH].data;
    end

endmodule

`endif // DL_PIPE_REG_SV
